// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, controller states and helpers
package pipe_ctrl_pkg;

  localparam int StallW = 6;
  typedef logic [StallW-1:0] stall_bus_t;

  localparam int StallBitPc  = 0;
  localparam int StallBitIf  = 1;
  localparam int StallBitId  = 2;
  localparam int StallBitEx  = 3;
  localparam int StallBitMem = 4;

  localparam stall_bus_t StallNone    = '0;
  localparam stall_bus_t StallLoadUse = (stall_bus_t'(1) << StallBitPc) |
                                        (stall_bus_t'(1) << StallBitIf) |
                                        (stall_bus_t'(1) << StallBitId);
  localparam stall_bus_t StallMulti   = StallLoadUse | (stall_bus_t'(1) << StallBitEx);
  localparam stall_bus_t StallMem     = StallMulti | (stall_bus_t'(1) << StallBitMem);

  typedef enum logic [1:0] {
    CtrlRun   = 2'd0,
    CtrlMulti = 2'd1,
    CtrlFlush = 2'd2
  } ctrl_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/sequencing signal bundle between core stages and pipe_ctrl
interface pipe_ctrl_if #(
  parameter int MULTI_LEN_W = 6
);
  logic                   id_reg1_read_i;
  logic                   id_reg2_read_i;
  logic [4:0]             id_reg1_addr_i;
  logic [4:0]             id_reg2_addr_i;
  logic                   ex_wreg_i;
  logic [4:0]             ex_wd_i;
  logic                   ex_is_load_i;
  logic                   ex_multi_start_i;
  logic [MULTI_LEN_W-1:0] ex_multi_len_i;
  logic                   mem_stall_req_i;
  logic                   flush_req_i;
  logic [5:0]             stall_o;
  logic                   flush_o;
  logic                   ex_multi_done_o;
  logic [15:0]            lu_bubble_cnt_o;

  modport master (
    output id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
    output ex_wreg_i, ex_wd_i, ex_is_load_i, ex_multi_start_i, ex_multi_len_i,
    output mem_stall_req_i, flush_req_i,
    input  stall_o, flush_o, ex_multi_done_o, lu_bubble_cnt_o
  );

  modport slave (
    input  id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
    input  ex_wreg_i, ex_wd_i, ex_is_load_i, ex_multi_start_i, ex_multi_len_i,
    input  mem_stall_req_i, flush_req_i,
    output stall_o, flush_o, ex_multi_done_o, lu_bubble_cnt_o
  );
endinterface

// File: rtl/load_use_det.sv
// rtl/load_use_det.sv - combinational load-use hazard comparator (load in EX vs ID reads)
module load_use_det (
  input  logic       i_reg1_read,
  input  logic       i_reg2_read,
  input  logic [4:0] i_reg1_addr,
  input  logic [4:0] i_reg2_addr,
  input  logic       i_ex_wreg,
  input  logic [4:0] i_ex_wd,
  input  logic       i_ex_is_load,
  output logic       o_lu_hit
);
  logic w_load_wr;
  logic w_reg1_match;
  logic w_reg2_match;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_load_wr    = i_ex_is_load & i_ex_wreg & (i_ex_wd != 5'd0);
  assign w_reg1_match = i_reg1_read & (i_reg1_addr == i_ex_wd);
  assign w_reg2_match = i_reg2_read & (i_reg2_addr == i_ex_wd);
  assign o_lu_hit     = w_load_wr & (w_reg1_match | w_reg2_match);
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall vector / flush sequencer for the five-stage core
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULTI_LEN_W  = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam int FcntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcntW-1:0] FcntLoad = FcntW'(FLUSH_CYCLES - 1);

  ctrl_state_t            r_state;
  ctrl_state_t            w_state_nxt;
  logic [MULTI_LEN_W-1:0] r_mcnt;
  logic [MULTI_LEN_W-1:0] w_mcnt_nxt;
  logic [FcntW-1:0]       r_fcnt;
  logic [FcntW-1:0]       w_fcnt_nxt;
  logic [15:0]            r_lu_cnt;
  logic [15:0]            w_lu_cnt_nxt;
  logic                   w_lu_hit;
  logic [MULTI_LEN_W-1:0] w_len;
  logic                   w_len_one;
  stall_bus_t             w_stall;
  logic                   w_flush;
  logic                   w_done;

  load_use_det u_lu (
    .i_reg1_read  (bus.id_reg1_read_i),
    .i_reg2_read  (bus.id_reg2_read_i),
    .i_reg1_addr  (bus.id_reg1_addr_i),
    .i_reg2_addr  (bus.id_reg2_addr_i),
    .i_ex_wreg    (bus.ex_wreg_i),
    .i_ex_wd      (bus.ex_wd_i),
    .i_ex_is_load (bus.ex_is_load_i),
    .o_lu_hit     (w_lu_hit)
  );

  // a zero length is treated as a single-cycle op
  assign w_len     = (bus.ex_multi_len_i == '0) ? MULTI_LEN_W'(1) : bus.ex_multi_len_i;
  assign w_len_one = (w_len == MULTI_LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= CtrlRun;
      r_mcnt   <= '0;
      r_fcnt   <= '0;
      r_lu_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcnt   <= w_mcnt_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mcnt_nxt   = r_mcnt;
    w_fcnt_nxt   = r_fcnt;
    w_lu_cnt_nxt = r_lu_cnt;
    case (r_state)
      CtrlRun: begin
        if (bus.flush_req_i) begin
          w_state_nxt = CtrlFlush;
          w_fcnt_nxt  = FcntLoad;
        end else if (bus.mem_stall_req_i) begin
          w_state_nxt = CtrlRun;
        end else if (bus.ex_multi_start_i) begin
          if (!w_len_one) begin
            w_state_nxt = CtrlMulti;
            w_mcnt_nxt  = w_len - MULTI_LEN_W'(2);
          end
        end else if (w_lu_hit) begin
          w_lu_cnt_nxt = sat_inc16(r_lu_cnt);
        end
      end
      CtrlMulti: begin
        if (bus.flush_req_i) begin
          w_state_nxt = CtrlFlush;
          w_mcnt_nxt  = '0;
          w_fcnt_nxt  = FcntLoad;
        end else if (bus.mem_stall_req_i) begin
          w_mcnt_nxt = r_mcnt;
        end else if (r_mcnt != '0) begin
          w_mcnt_nxt = r_mcnt - MULTI_LEN_W'(1);
        end else begin
          w_state_nxt = CtrlRun;
        end
      end
      CtrlFlush: begin
        if (bus.flush_req_i) begin
          w_fcnt_nxt = FcntLoad;
        end else if (r_fcnt == '0) begin
          w_state_nxt = CtrlRun;
        end else begin
          w_fcnt_nxt = r_fcnt - FcntW'(1);
        end
      end
      default: w_state_nxt = CtrlRun;
    endcase
  end

  // outputs are held low for the whole time reset is asserted
  always_comb begin
    w_stall = StallNone;
    w_flush = 1'b0;
    w_done  = 1'b0;
    if (rst) begin
      case (r_state)
        CtrlRun: begin
          if (bus.flush_req_i) begin
            w_flush = 1'b1;
          end else if (bus.mem_stall_req_i) begin
            w_stall = StallMem;
          end else if (bus.ex_multi_start_i) begin
            if (w_len_one) w_done = 1'b1;
            else           w_stall = StallMulti;
          end else if (w_lu_hit) begin
            w_stall = StallLoadUse;
          end
        end
        CtrlMulti: begin
          if (bus.flush_req_i)          w_flush = 1'b1;
          else if (bus.mem_stall_req_i) w_stall = StallMem;
          else if (r_mcnt != '0)        w_stall = StallMulti;
          else                          w_done  = 1'b1;
        end
        CtrlFlush: w_flush = 1'b1;
        default: w_stall = StallNone;
      endcase
    end
  end

  assign bus.stall_o         = w_stall;
  assign bus.flush_o         = w_flush;
  assign bus.ex_multi_done_o = w_done;
  assign bus.lu_bubble_cnt_o = r_lu_cnt;
endmodule
